seq_det_ctrl: RTL and testbench

- Controller that feeds a 1-bit overlapping Moore sequence detector, fixed pattern "1001", from a word stream.
- Accepts WORD_W-bit words over a valid/ready handshake and serializes them MSB-first into the detector.
- Samples the detector output, counts matches per frame, raises a threshold interrupt, and clears the detector between frames.
- Sits between a parallel producer and the detector instance; the paired detector wrapper advances state only when det_en=1.

---
 rtl/seq_det_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serializes valid/ready words into an overlapping "1001" Moore detector and counts matches per frame.
// Build macro SEQ_DET_CTRL_LSB_FIRST_EN selects LSB-first serialization; the default build is MSB-first.
//
// state | meaning
// IDLE  | no frame open, ready for the first word of a frame
// SHIFT | one bit per cycle into the detector, det_en high
// WAIT  | frame open, previous word done, waiting for the next word
// FLUSH | one quiet cycle so the last bit shows up on det_dout
// CLR   | clear the detector, pulse frame_done, match_cnt final
module seq_det_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [WORD_W-1:0] s_data_i,
  input  logic              s_last_i,
  input  logic [CNT_W-1:0]  thresh_i,
  output logic              det_din_o,
  output logic              det_en_o,
  output logic              det_clr_o,
  input  logic              det_dout_i,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic              irq_o,
  output logic              frame_done_o
);

  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_CLR   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               cur_last_q, cur_last_d;
  logic               det_en_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;
  logic               irq_done_q, irq_done_d;

  logic               s_ready;
  logic               det_en;
  logic               det_clr;
  logic               frame_done;
  logic               load;
  logic               clr_cnt;
  logic [WORD_W-1:0]  sreg_shifted;
  logic               det_din;
  logic               hit;
  logic               cnt_sat;
  logic [CNT_W-1:0]   cnt_inc;

`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
  assign sreg_shifted = {1'b0, sreg_q[WORD_W-1:1]};
  assign det_din      = sreg_q[0];
`else
  assign sreg_shifted = {sreg_q[WORD_W-2:0], 1'b0};
  assign det_din      = sreg_q[WORD_W-1];
`endif

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_idx_d  = bit_idx_q;
    cur_last_d = cur_last_q;
    s_ready    = 1'b0;
    det_en     = 1'b0;
    det_clr    = 1'b0;
    frame_done = 1'b0;
    load       = 1'b0;
    clr_cnt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid_i) begin
          load    = 1'b1;
          clr_cnt = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_en    = 1'b1;
        sreg_d    = sreg_shifted;
        bit_idx_d = bit_idx_q - IDX_W'(1);
        if (bit_idx_q == '0) begin
          if (cur_last_q) begin
            state_d = ST_FLUSH;
          end else begin
            // back-to-back words keep shifting without a bubble
            s_ready = 1'b1;
            if (s_valid_i) load = 1'b1;
            else           state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        s_ready = 1'b1;
        if (s_valid_i) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
        state_d = ST_CLR;
      end
      ST_CLR: begin
        det_clr    = 1'b1;
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      sreg_d     = s_data_i;
      bit_idx_d  = IDX_W'(WORD_W - 1);
      cur_last_d = s_last_i;
    end
  end

  // det_dout reflects the bit driven one cycle earlier, so qualify with det_en delayed
  assign hit     = det_en_q & det_dout_i;
  assign cnt_sat = &cnt_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    cnt_d      = cnt_q;
    irq_d      = 1'b0;
    irq_done_d = irq_done_q;
    if (clr_cnt) begin
      cnt_d      = '0;
      irq_done_d = 1'b0;
    end else if (hit && !cnt_sat) begin
      cnt_d = cnt_inc;
      if ((thresh_i != '0) && (cnt_inc == thresh_i) && !irq_done_q) begin
        irq_d      = 1'b1;
        irq_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      bit_idx_q  <= '0;
      cur_last_q <= 1'b0;
      det_en_q   <= 1'b0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
      irq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_idx_q  <= bit_idx_d;
      cur_last_q <= cur_last_d;
      det_en_q   <= det_en;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
      irq_done_q <= irq_done_d;
    end
  end

  // ready stays low for the whole time reset is held, even though the state is IDLE
  assign s_ready_o    = s_ready & rst_n_i;
  assign det_din_o    = det_din;
  assign det_en_o     = det_en;
  assign det_clr_o    = det_clr;
  assign match_cnt_o  = cnt_q;
  assign irq_o        = irq_q;
  assign frame_done_o = frame_done;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: two instances (CNT_W=8 and CNT_W=2) share stimulus,
// each feeding a behavioural overlapping "1001" Moore detector.
`timescale 1ns/1ps
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic [7:0] thresh_a;
  logic [1:0] thresh_b;

  logic       s_ready_a, det_din_a, det_en_a, det_clr_a, det_dout_a, irq_a, fd_a;
  logic [7:0] cnt_a;
  logic       s_ready_b, det_din_b, det_en_b, det_clr_b, det_dout_b, irq_b, fd_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seq_det_ctrl #(.WORD_W(8), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready_a),
    .s_data_i(s_data), .s_last_i(s_last), .thresh_i(thresh_a),
    .det_din_o(det_din_a), .det_en_o(det_en_a), .det_clr_o(det_clr_a),
    .det_dout_i(det_dout_a), .match_cnt_o(cnt_a), .irq_o(irq_a), .frame_done_o(fd_a)
  );

  seq_det_ctrl #(.WORD_W(8), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready_b),
    .s_data_i(s_data), .s_last_i(s_last), .thresh_i(thresh_b),
    .det_din_o(det_din_b), .det_en_o(det_en_b), .det_clr_o(det_clr_b),
    .det_dout_i(det_dout_b), .match_cnt_o(cnt_b), .irq_o(irq_b), .frame_done_o(fd_b)
  );

  // detector states: 0 none, 1 "1", 2 "10", 3 "100", 4 "1001" (output high)
  function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd1 : 3'd2;
      3'd2:    return b ? 3'd1 : 3'd3;
      3'd3:    return b ? 3'd4 : 3'd0;
      default: return b ? 3'd1 : 3'd2;
    endcase
  endfunction

  logic [2:0] dst_a, dst_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dst_a <= 3'd0;
    else if (det_clr_a)  dst_a <= 3'd0;
    else if (det_en_a)   dst_a <= det_next(dst_a, det_din_a);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dst_b <= 3'd0;
    else if (det_clr_b)  dst_b <= 3'd0;
    else if (det_en_b)   dst_b <= det_next(dst_b, det_din_b);
  end

  assign det_dout_a = (dst_a == 3'd4);
  assign det_dout_b = (dst_b == 3'd4);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // frame description and per-frame observations
  logic [7:0] wd[3];
  int         wfrom[3];
  int         nw;
  int         acc_cyc[3];
  int         fd_cyc, cnt_fd_a, cnt_fd_b, clr_fd, rdy_after, rdy8;
  int         irq_n_a, irq_n_b, irq_val_a, irq_cyc_a, en_n, cnt_c1_a, cnt_c1_b;
  logic [7:0] bits;

  // Call at #1 after a rising edge with both DUTs idle; that cycle is cycle 0.
  task automatic run_frame();
    int  cyc;
    int  wi;
    bit  done;
    cyc = 0; wi = 0; done = 0;
    fd_cyc = -1; irq_n_a = 0; irq_n_b = 0; irq_val_a = -1; irq_cyc_a = -1;
    en_n = 0; rdy_after = 0; rdy8 = -1; bits = '0; cnt_c1_a = -1; cnt_c1_b = -1;
    for (int k = 0; k < 3; k++) acc_cyc[k] = -1;
    for (int k = 0; k < 300 && !done; k++) begin
      if (wi < nw && cyc >= wfrom[wi]) begin
        s_valid = 1'b1;
        s_data  = wd[wi];
        s_last  = (wi == nw - 1);
      end else begin
        s_valid = 1'b0;
        s_data  = 8'hFF;
        s_last  = 1'b1;
      end
      if (s_valid && s_ready_a) begin
        acc_cyc[wi] = cyc;
        wi++;
      end
      @(posedge clk); #1;
      cyc++;
      if (det_en_a) begin
        en_n++;
        bits = {bits[6:0], det_din_a};
      end
      if (cyc == 1) begin
        cnt_c1_a = cnt_a;
        cnt_c1_b = cnt_b;
      end
      if (cyc == 8) rdy8 = s_ready_a;
      if (irq_a) begin
        irq_n_a++;
        irq_val_a = cnt_a;
        irq_cyc_a = cyc;
      end
      if (irq_b) irq_n_b++;
      if (fd_a) begin
        fd_cyc   = cyc;
        cnt_fd_a = cnt_a;
        cnt_fd_b = cnt_b;
        clr_fd   = det_clr_a;
      end
      if (fd_cyc >= 0 && cyc == fd_cyc + 1) begin
        rdy_after = s_ready_a;
        done = 1;
      end
    end
    s_valid = 1'b0;
    if (!done) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    thresh_a = 8'd0; thresh_b = 2'd0;

    // reset state
    #1;
    chk("rst_s_ready", s_ready_a, 1'b0);
    chk("rst_cnt", cnt_a, 8'd0);
    chk("rst_det_clr", det_clr_a, 1'b0);
    chk("rst_det_en", det_en_a, 1'b0);
    chk("rst_fd", fd_a, 1'b0);
    chk("rst_irq", irq_a, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_s_ready", s_ready_a, 1'b1);

    // single word 0x92: bits 1,0,0,1,0,0,1,0 -> 2 matches
    nw = 1; wd[0] = 8'h92; wfrom[0] = 0;
    run_frame();
    chk("w1_bits", bits, 8'h92);
    chk("w1_en_cycles", en_n, 8);
    chk("w1_fd_cycle", fd_cyc, 10);
    chk("w1_clr_with_fd", clr_fd, 1'b1);
    chk("w1_cnt", cnt_fd_a, 2);
    chk("w1_ready_after", rdy_after, 1'b1);
    chk("w1_no_irq", irq_n_a, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("w1_cnt_held", cnt_a, 8'd2);

    // two words 0x01, 0x20 gapless: one match across the boundary
    nw = 2; wd[0] = 8'h01; wd[1] = 8'h20; wfrom[0] = 0; wfrom[1] = 0;
    run_frame();
    chk("g0_cnt_cleared", cnt_c1_a, 0);
    chk("g0_ready_c8", rdy8, 1'b1);
    chk("g0_acc2", acc_cyc[1], 8);
    chk("g0_fd_cycle", fd_cyc, 18);
    chk("g0_cnt", cnt_fd_a, 1);
    chk("g0_en_cycles", en_n, 16);

    // same frame with a 3-cycle WAIT gap
    wfrom[1] = 11;
    run_frame();
    chk("g3_acc2", acc_cyc[1], 11);
    chk("g3_fd_cycle", fd_cyc, 21);
    chk("g3_cnt", cnt_fd_a, 1);
    chk("g3_en_cycles", en_n, 16);

    // thresh=3, 0x92 x2: matches land in cycles 6,9,14,17
    thresh_a = 8'd3; thresh_b = 2'd3;
    nw = 2; wd[0] = 8'h92; wd[1] = 8'h92; wfrom[0] = 0; wfrom[1] = 0;
    run_frame();
    chk("th_irq_count", irq_n_a, 1);
    chk("th_irq_val", irq_val_a, 3);
    chk("th_irq_cycle", irq_cyc_a, 14);
    chk("th_cnt", cnt_fd_a, 4);
    chk("th_irq_count_sat", irq_n_b, 1);
    chk("th_cnt_sat", cnt_fd_b, 3);

    // thresh=0, 0x92 x3: 6 matches, narrow counter saturates at 3
    thresh_a = 8'd0; thresh_b = 2'd0;
    nw = 3; wd[2] = 8'h92; wfrom[2] = 0;
    run_frame();
    chk("sat_fd_cycle", fd_cyc, 26);
    chk("sat_cnt_wide", cnt_fd_a, 6);
    chk("sat_cnt_narrow", cnt_fd_b, 3);
    chk("sat_no_irq", irq_n_a + irq_n_b, 0);

    // 0x00 frame: counter cleared at accept
    nw = 1; wd[0] = 8'h00;
    run_frame();
    chk("z_cnt_cleared", cnt_c1_b, 0);
    chk("z_cnt_narrow", cnt_fd_b, 0);
    chk("z_cnt_wide", cnt_fd_a, 0);

    // reset in the middle of SHIFT
    s_valid = 1'b1; s_data = 8'h92; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_shifting", det_en_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", s_ready_a, 1'b0);
    chk("mid_rst_en", det_en_a, 1'b0);
    chk("mid_rst_din", det_din_a, 1'b0);
    chk("mid_rst_cnt", cnt_a, 8'd0);
    @(posedge clk); #1;
    chk("mid_rst_fd", fd_a, 1'b0);
    chk("mid_rst_clr", det_clr_a, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", s_ready_a, 1'b1);
    chk("mid_rel_fd", fd_a, 1'b0);
    chk("mid_rel_irq", irq_a, 1'b0);

    nw = 1; wd[0] = 8'h92; wfrom[0] = 0;
    run_frame();
    chk("re_bits", bits, 8'h92);
    chk("re_fd_cycle", fd_cyc, 10);
    chk("re_cnt", cnt_fd_a, 2);
    chk("re_ready_after", rdy_after, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
